// File: rtl/sirv_mrom_icb_arb.sv
// sirv_mrom_icb_arb
//   Two-port ICB front-end for a combinational 4KB mask ROM. Port m0 (IFU) and
//   port m1 (LSU/debug) share one rom_addr/rom_dout pair. Each accepted command
//   gets one registered response from a single response buffer. The buffer
//   reloads on the same edge its response is consumed, so throughput is one
//   command per cycle.
//   Optional build macro SIRV_MROM_ARB_RR_EN selects round-robin tie-breaking.
//   Without it, m0 wins every tie.
module sirv_mrom_icb_arb #(
  parameter int          AW        = 12,
  parameter int          DW        = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_icb_cmd_valid,
  output logic          m0_icb_cmd_ready,
  input  logic [31:0]   m0_icb_cmd_addr,
  input  logic          m0_icb_cmd_read,
  output logic          m0_icb_rsp_valid,
  input  logic          m0_icb_rsp_ready,
  output logic          m0_icb_rsp_err,
  output logic [DW-1:0] m0_icb_rsp_rdata,
  input  logic          m1_icb_cmd_valid,
  output logic          m1_icb_cmd_ready,
  input  logic [31:0]   m1_icb_cmd_addr,
  input  logic          m1_icb_cmd_read,
  output logic          m1_icb_rsp_valid,
  input  logic          m1_icb_rsp_ready,
  output logic          m1_icb_rsp_err,
  output logic [DW-1:0] m1_icb_rsp_rdata,
  output logic [AW-3:0] rom_addr,
  input  logic [DW-1:0] rom_dout
);

  // IDLE: the response buffer is empty. RSP: the buffer holds a response.
  typedef enum logic {S_IDLE = 1'b0, S_RSP = 1'b1} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_own;
  logic          r_err;
  logic [DW-1:0] r_data;

  logic          w_own_rsp_ready;
  logic          w_buf_free;
  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_hs;
  logic [31:0]   w_sel_addr;
  logic          w_sel_read;
  logic          w_err;
  logic          w_m0_rsp_valid;
  logic          w_m1_rsp_valid;

  // The buffer can accept a new command when it is empty, or when its owner
  // consumes the held response on this edge. Only the owner's ready is used.
  assign w_own_rsp_ready = r_own ? m1_icb_rsp_ready : m0_icb_rsp_ready;
  assign w_buf_free      = (r_state == S_IDLE) | w_own_rsp_ready;

`ifdef SIRV_MROM_ARB_RR_EN
  logic r_last_grant;

  // On a tie, the port that was not granted last wins.
  // r_last_grant resets to 1, so m0 wins the first tie.
  assign w_gnt1 = m1_icb_cmd_valid & (~m0_icb_cmd_valid | ~r_last_grant);

  // Record the winner of every command handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_last_grant <= 1'b1;
    else if (w_hs) r_last_grant <= w_gnt1;
  end
`else
  // Fixed priority: m1 is granted only when m0 is not requesting.
  assign w_gnt1 = m1_icb_cmd_valid & ~m0_icb_cmd_valid;
`endif

  assign w_gnt0           = m0_icb_cmd_valid & ~w_gnt1;
  assign m0_icb_cmd_ready = w_buf_free & w_gnt0;
  assign m1_icb_cmd_ready = w_buf_free & w_gnt1;
  assign w_hs             = w_buf_free & (w_gnt0 | w_gnt1);

  // When neither port is granted, the mux steers m0's address to the ROM.
  // The ROM output is unused in that case.
  assign w_sel_addr = w_gnt1 ? m1_icb_cmd_addr : m0_icb_cmd_addr;
  assign w_sel_read = w_gnt1 ? m1_icb_cmd_read : m0_icb_cmd_read;
  assign rom_addr   = w_sel_addr[AW-1:2];

  // Flag writes, misaligned accesses and addresses outside the ROM window.
  assign w_err = ~w_sel_read
               | (w_sel_addr[1:0] != 2'b00)
               | (w_sel_addr[31:AW] != BASE_ADDR[31:AW]);

  // State register.
  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples values from before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state: a handshake fills the buffer. The owner's ready with no new
  // command empties it.
  always_comb begin
    // NOTE: assign the default first so every path drives the signal and no
    // latch is inferred.
    w_state_nxt = r_state;
    if (w_hs)                                       w_state_nxt = S_RSP;
    else if ((r_state == S_RSP) && w_own_rsp_ready) w_state_nxt = S_IDLE;
  end

  // Load the response buffer on every handshake.
  // NOTE: the data register is reset as well. This makes a response discarded
  // by reset leave no stale read data behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_own  <= 1'b0;
      r_err  <= 1'b0;
      r_data <= '0;
    end else if (w_hs) begin
      r_own  <= w_gnt1;
      r_err  <= w_err;
      r_data <= w_err ? '0 : rom_dout;
    end
  end

  // Only the owning port sees a valid response. err/rdata read zero while
  // that port's response is not valid.
  assign w_m0_rsp_valid   = (r_state == S_RSP) & ~r_own;
  assign w_m1_rsp_valid   = (r_state == S_RSP) &  r_own;
  assign m0_icb_rsp_valid = w_m0_rsp_valid;
  assign m1_icb_rsp_valid = w_m1_rsp_valid;
  assign m0_icb_rsp_err   = w_m0_rsp_valid & r_err;
  assign m1_icb_rsp_err   = w_m1_rsp_valid & r_err;
  assign m0_icb_rsp_rdata = w_m0_rsp_valid ? r_data : '0;
  assign m1_icb_rsp_rdata = w_m1_rsp_valid ? r_data : '0;

endmodule

// File: tb/tb_sirv_mrom_icb_arb.sv
// Testbench for sirv_mrom_icb_arb.
//   A behavioural ROM model drives rom_dout.
//   Expected responses are pushed to a scoreboard queue when a grant is
//   expected. They are popped when the owning port takes the response.
module tb_sirv_mrom_icb_arb;

  logic        clk;
  logic        rst;
  logic        m0_icb_cmd_valid, m0_icb_cmd_ready, m0_icb_cmd_read;
  logic [31:0] m0_icb_cmd_addr;
  logic        m0_icb_rsp_valid, m0_icb_rsp_ready, m0_icb_rsp_err;
  logic [31:0] m0_icb_rsp_rdata;
  logic        m1_icb_cmd_valid, m1_icb_cmd_ready, m1_icb_cmd_read;
  logic [31:0] m1_icb_cmd_addr;
  logic        m1_icb_rsp_valid, m1_icb_rsp_ready, m1_icb_rsp_err;
  logic [31:0] m1_icb_rsp_rdata;
  logic [9:0]  rom_addr;
  logic [31:0] rom_dout;

  typedef struct {
    int          port;
    logic        err;
    logic [31:0] data;
  } rsp_t;

  rsp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  sirv_mrom_icb_arb dut (
    .clk              (clk),
    .rst              (rst),
    .m0_icb_cmd_valid (m0_icb_cmd_valid),
    .m0_icb_cmd_ready (m0_icb_cmd_ready),
    .m0_icb_cmd_addr  (m0_icb_cmd_addr),
    .m0_icb_cmd_read  (m0_icb_cmd_read),
    .m0_icb_rsp_valid (m0_icb_rsp_valid),
    .m0_icb_rsp_ready (m0_icb_rsp_ready),
    .m0_icb_rsp_err   (m0_icb_rsp_err),
    .m0_icb_rsp_rdata (m0_icb_rsp_rdata),
    .m1_icb_cmd_valid (m1_icb_cmd_valid),
    .m1_icb_cmd_ready (m1_icb_cmd_ready),
    .m1_icb_cmd_addr  (m1_icb_cmd_addr),
    .m1_icb_cmd_read  (m1_icb_cmd_read),
    .m1_icb_rsp_valid (m1_icb_rsp_valid),
    .m1_icb_rsp_ready (m1_icb_rsp_ready),
    .m1_icb_rsp_err   (m1_icb_rsp_err),
    .m1_icb_rsp_rdata (m1_icb_rsp_rdata),
    .rom_addr         (rom_addr),
    .rom_dout         (rom_dout)
  );

  always #5 clk = ~clk;

  // Behavioural mask ROM. Words 0..2 hold the boot image.
  // Other words hold an index-tagged pattern.
  function automatic logic [31:0] rom_model(input logic [9:0] idx);
    case (idx)
      10'd0:   return 32'h7ffff297;
      10'd1:   return 32'h00028067;
      10'd2:   return 32'h00000000;
      default: return {16'hA5C3, 6'b0, idx};
    endcase
  endfunction

  assign rom_dout = rom_model(rom_addr);

  function automatic rsp_t exp_rsp(input int port, input logic [31:0] addr, input logic rd);
    rsp_t r;
    r.port = port;
    r.err  = ~rd | (addr[1:0] != 2'b00) | (addr[31:12] != 20'h00001);
    r.data = r.err ? 32'h0 : rom_model(addr[11:2]);
    return r;
  endfunction

  // Drives one cycle from a negedge, checks the held response and the
  // expected grant, then advances to the next negedge.
  // exp_gnt: -1 = no grant, 0 = m0, 1 = m1.
  task automatic drive_cycle(input logic v0, input logic [31:0] a0, input logic rd0,
                             input logic rr0, input logic v1, input logic [31:0] a1,
                             input logic rd1, input logic rr1, input int exp_gnt,
                             input string tag);
    rsp_t e;
    m0_icb_cmd_valid = v0; m0_icb_cmd_addr = a0; m0_icb_cmd_read = rd0; m0_icb_rsp_ready = rr0;
    m1_icb_cmd_valid = v1; m1_icb_cmd_addr = a1; m1_icb_cmd_read = rd1; m1_icb_rsp_ready = rr1;
    #1;
    n_checks++;
    if (sb.size() > 0) begin
      e = sb[0];
      if (e.port == 0) begin
        if (m0_icb_rsp_valid !== 1'b1 || m1_icb_rsp_valid !== 1'b0 ||
            m0_icb_rsp_err !== e.err || m0_icb_rsp_rdata !== e.data) begin
          n_fail++;
          $display("FAIL %s m0_rsp: got v0=%b v1=%b err=%b rdata=%h, want v0=1 v1=0 err=%b rdata=%h",
                   tag, m0_icb_rsp_valid, m1_icb_rsp_valid, m0_icb_rsp_err, m0_icb_rsp_rdata,
                   e.err, e.data);
        end
        if (rr0) void'(sb.pop_front());
      end else begin
        if (m1_icb_rsp_valid !== 1'b1 || m0_icb_rsp_valid !== 1'b0 ||
            m1_icb_rsp_err !== e.err || m1_icb_rsp_rdata !== e.data) begin
          n_fail++;
          $display("FAIL %s m1_rsp: got v0=%b v1=%b err=%b rdata=%h, want v0=0 v1=1 err=%b rdata=%h",
                   tag, m0_icb_rsp_valid, m1_icb_rsp_valid, m1_icb_rsp_err, m1_icb_rsp_rdata,
                   e.err, e.data);
        end
        if (rr1) void'(sb.pop_front());
      end
    end else begin
      if (m0_icb_rsp_valid !== 1'b0 || m1_icb_rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL %s no_rsp: got v0=%b v1=%b, want 0 0",
                 tag, m0_icb_rsp_valid, m1_icb_rsp_valid);
      end
    end
    n_checks++;
    if (m0_icb_cmd_ready !== (exp_gnt == 0) || m1_icb_cmd_ready !== (exp_gnt == 1)) begin
      n_fail++;
      $display("FAIL %s grant: got ready0=%b ready1=%b, want grant=%0d",
               tag, m0_icb_cmd_ready, m1_icb_cmd_ready, exp_gnt);
    end
    if (exp_gnt == 0)      sb.push_back(exp_rsp(0, a0, rd0));
    else if (exp_gnt == 1) sb.push_back(exp_rsp(1, a1, rd1));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    m0_icb_cmd_valid = 0; m0_icb_cmd_addr = 0; m0_icb_cmd_read = 0; m0_icb_rsp_ready = 0;
    m1_icb_cmd_valid = 0; m1_icb_cmd_addr = 0; m1_icb_cmd_read = 0; m1_icb_rsp_ready = 0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    idle_inputs();
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (m0_icb_rsp_valid !== 0 || m1_icb_rsp_valid !== 0 || m0_icb_rsp_err !== 0 ||
        m1_icb_rsp_err !== 0 || m0_icb_rsp_rdata !== 0 || m1_icb_rsp_rdata !== 0 ||
        m0_icb_cmd_ready !== 0 || m1_icb_cmd_ready !== 0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b%b err=%b%b rd0=%h rd1=%h rdy=%b%b, want all zero",
               m0_icb_rsp_valid, m1_icb_rsp_valid, m0_icb_rsp_err, m1_icb_rsp_err,
               m0_icb_rsp_rdata, m1_icb_rsp_rdata, m0_icb_cmd_ready, m1_icb_cmd_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    drive_cycle(1, 32'h0000_1000, 1, 1, 0, 0, 0, 1, 0,  "t1_m0_read");
    drive_cycle(0, 0, 0, 1, 0, 0, 0, 1, -1, "t1_m0_rsp");
    drive_cycle(0, 0, 0, 1, 0, 0, 0, 1, -1, "t1_drain");
  endtask

  task automatic test_errors();
    drive_cycle(0, 0, 0, 1, 1, 32'h0000_1004, 0, 1, 1,  "t2_m1_write");
    drive_cycle(0, 0, 0, 1, 1, 32'h0000_1002, 1, 1, 1,  "t2_m1_misalign");
    drive_cycle(0, 0, 0, 1, 1, 32'h0000_2000, 1, 1, 1,  "t2_m1_window");
    drive_cycle(0, 0, 0, 1, 1, 32'h0000_100C, 1, 1, 1,  "t2_m1_ok");
    drive_cycle(0, 0, 0, 1, 0, 0, 0, 1, -1, "t2_drain");
    drive_cycle(0, 0, 0, 1, 0, 0, 0, 1, -1, "t2_idle");
  endtask

  task automatic test_stall();
    drive_cycle(1, 32'h0000_1004, 1, 0, 0, 0, 0, 0, 0, "t3_m0_read");
    for (int i = 0; i < 5; i++)
      // m1's rsp_ready is high but m1 does not own the response. It must be ignored.
      drive_cycle(0, 0, 0, 0, 1, 32'h0000_1000, 1, 1, -1, "t3_stall");
    drive_cycle(0, 0, 0, 1, 1, 32'h0000_1000, 1, 1, 1,  "t3_release");
    drive_cycle(0, 0, 0, 1, 0, 0, 0, 1, -1, "t3_m1_rsp");
    drive_cycle(0, 0, 0, 1, 0, 0, 0, 1, -1, "t3_idle");
  endtask

  task automatic test_arbitration();
    int exp_seq[4];
    reset_dut();
`ifdef SIRV_MROM_ARB_RR_EN
    exp_seq = '{0, 1, 0, 1};
`else
    exp_seq = '{0, 0, 0, 0};
`endif
    for (int i = 0; i < 4; i++)
      drive_cycle(1, 32'h0000_1008, 1, 1, 1, 32'h0000_1010, 1, 1, exp_seq[i], "t4_tie");
    drive_cycle(0, 0, 0, 1, 1, 32'h0000_1010, 1, 1, 1,  "t4_m1_alone");
    drive_cycle(0, 0, 0, 1, 0, 0, 0, 1, -1, "t4_drain");
  endtask

  task automatic test_back_to_back();
    drive_cycle(1, 32'h0000_1000, 1, 1, 0, 0, 0, 0, 0,  "t5_b2b0");
    drive_cycle(1, 32'h0000_1004, 1, 1, 0, 0, 0, 0, 0,  "t5_b2b1");
    drive_cycle(1, 32'h0000_1008, 1, 1, 0, 0, 0, 0, 0,  "t5_b2b2");
    drive_cycle(0, 0, 0, 1, 0, 0, 0, 0, -1, "t5_drain");
    drive_cycle(0, 0, 0, 1, 0, 0, 0, 0, -1, "t5_idle");
  endtask

  task automatic test_async_reset();
    drive_cycle(1, 32'h0000_1004, 1, 0, 0, 0, 0, 0, 0, "t6_m0_read");
    idle_inputs();
    #1;
    n_checks++;
    if (m0_icb_rsp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL t6_pre_reset: got m0_rsp_valid=%b, want 1", m0_icb_rsp_valid);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (m0_icb_rsp_valid !== 1'b0 || m1_icb_rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL t6_async_drop: got v0=%b v1=%b, want 0 0",
               m0_icb_rsp_valid, m1_icb_rsp_valid);
    end
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive_cycle(1, 32'h0000_1000, 1, 1, 1, 32'h0000_1004, 1, 1, 0, "t6_first_tie");
    drive_cycle(0, 0, 0, 1, 0, 0, 0, 1, -1, "t6_drain");
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_single_read();
    test_errors();
    test_stall();
    test_arbitration();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
